di_term_arbiter: RTL and testbench
==================================

DI_TERM_ARBITER -- requirements
Module: di_term_arbiter

Interface
REQ-001 SHALL have parameter NUM_TERMS, default 4: number of attached terminals, legal range 1..8.
REQ-002 SHALL have parameter TERM_ADDRS, default {16'd3,16'd2,16'd1,16'd0}: packed 16-bit terminal addresses, entry i at bits [16i+15:16i].
REQ-003 SHALL have parameter TIMEOUT, default 256: number of consecutive not-ready cycles before a forced completion, legal range 2..65535.
REQ-004 SHALL have parameter ERR_DATA, default 16'hDEAD: data returned on forced or unmapped reads.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 ifclk  in  1  sole clock; all state changes on its rising edge.
REQ-007 resetb  in  1  asynchronous active-low reset.
REQ-008 di_term_addr  in  16  terminal address from the host interface.
REQ-009 di_read_mode / di_write_mode  in  1 each  read or write transaction in progress.
REQ-010 di_read_req / di_write  in  1 each  read request strobe / write data strobe.
REQ-011 term_reg_datao  in  16*NUM_TERMS  per-terminal read data.
REQ-012 term_read_rdy / term_write_rdy  in  NUM_TERMS each  per-terminal ready.
REQ-013 err_clear  in  1  synchronous clear of error status.
REQ-014 di_reg_datao  out  16  registered read data to the host interface.
REQ-015 di_read_rdy / di_write_rdy  out  1 each  ready to the host interface.
REQ-016 term_sel  out  NUM_TERMS  one-hot decode of di_term_addr.
REQ-017 timeout_err  out  1  sticky flag: at least one forced completion since the last clear.
REQ-018 err_count  out  8  number of forced completions, saturating.

Function
REQ-019 term_sel[i] SHALL be the combinational result di_term_addr == TERM_ADDRS[i]; duplicate addresses SHALL select the lowest index only; no match gives all zeros (unmapped).
REQ-020 The FSM SHALL have the states IDLE, ACTIVE and FORCED.
REQ-021 IDLE -> ACTIVE when di_read_mode or di_write_mode is high; any state -> IDLE when both modes are low.
REQ-022 In ACTIVE, "rdy" SHALL mean the selected term_read_rdy when di_read_mode is high, otherwise the selected term_write_rdy.
REQ-023 In ACTIVE, the 16-bit wait counter SHALL increment on each cycle with rdy low and clear on each cycle with rdy high; it SHALL be 0 in IDLE and FORCED.
REQ-024 When wait counter == TIMEOUT-1 and rdy is low, the FSM SHALL enter FORCED on the next edge; on that same edge timeout_err SHALL be set and err_count SHALL increment, saturating at 255.
REQ-025 In IDLE and ACTIVE, di_read_rdy and di_write_rdy SHALL combinationally equal the selected terminal's term_read_rdy and term_write_rdy.
REQ-026 In FORCED, di_read_rdy and di_write_rdy SHALL be 1 until both modes deassert.
REQ-027 For an unmapped address, di_read_rdy and di_write_rdy SHALL be 1 in every state, with no timeout and no error count.
REQ-028 di_reg_datao SHALL register every cycle, one-cycle latency: ERR_DATA if the next state is FORCED or the address is unmapped, otherwise the selected term_reg_datao.
REQ-029 Writes in FORCED or to an unmapped address SHALL be discarded (term_sel is zeros for unmapped; in FORCED term_sel stays driven, and the discard is the terminal's responsibility).
REQ-030 A change of di_term_addr while in ACTIVE SHALL clear the wait counter.
REQ-031 err_clear SHALL zero timeout_err and err_count; if it coincides with a new timeout, the result SHALL be timeout_err = 1 and err_count = 1.

Reset
REQ-032 While resetb is low: FSM = IDLE, wait counter = 0, di_reg_datao = 16'h0000, timeout_err = 0, err_count = 0; di_read_rdy and di_write_rdy SHALL be forced to 0.
REQ-033 An in-flight transaction SHALL be abandoned by reset; after release the FSM SHALL re-enter ACTIVE if a mode is still high.

Verification
REQ-034 Address 1, term_read_rdy[1] = 1, term data 16'h1234, read -> di_read_rdy = 1, di_reg_datao = 16'h1234 one cycle later, no error.
REQ-035 TIMEOUT = 8, address 2, term_read_rdy[2] held 0 -> FORCED after 8 wait cycles, di_reg_datao = 16'hDEAD, timeout_err = 1, err_count = 1; dropping the mode -> IDLE.
REQ-036 Address 16'h00FF (unmapped), read and write -> term_sel = 0, both rdy = 1, data = 16'hDEAD, err_count unchanged.
REQ-037 TIMEOUT = 8, ready low for 7 cycles then high for 1, repeated 10 times -> never FORCED; 300 forced timeouts -> err_count = 255; err_clear together with a timeout -> err_count = 1.
REQ-038 resetb pulsed low in the middle of an ACTIVE wait -> outputs take the reset values immediately; after release with the mode high -> ACTIVE with the counter restarting at 0.

Source files
------------

// File: rtl/di_term_arbiter.sv
// Arbitrates host-interface reads and writes across NUM_TERMS terminals.
// If the selected terminal stays not-ready too long, the arbiter forces completion and returns ERR_DATA.
module di_term_arbiter #(
    parameter int                      NUM_TERMS  = 4,
    parameter logic [16*NUM_TERMS-1:0] TERM_ADDRS = {16'd3, 16'd2, 16'd1, 16'd0},
    parameter int                      TIMEOUT    = 256,
    parameter logic [15:0]             ERR_DATA   = 16'hDEAD
) (
    input  logic                      ifclk,
    input  logic                      resetb,
    input  logic [15:0]               di_term_addr,
    input  logic                      di_read_mode,
    input  logic                      di_write_mode,
    input  logic                      di_read_req,
    input  logic                      di_write,
    input  logic [16*NUM_TERMS-1:0]   term_reg_datao,
    input  logic [NUM_TERMS-1:0]      term_read_rdy,
    input  logic [NUM_TERMS-1:0]      term_write_rdy,
    input  logic                      err_clear,
    output logic [15:0]               di_reg_datao,
    output logic                      di_read_rdy,
    output logic                      di_write_rdy,
    output logic [NUM_TERMS-1:0]      term_sel,
    output logic                      timeout_err,
    output logic [7:0]                err_count
);

    typedef enum logic [1:0] {IDLE, ACTIVE, FORCED} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic [15:0] addr_q;
    logic [15:0] sel_data;
    logic        mapped, sel_rrdy, sel_wrdy, rdy, any_mode, addr_chg, timeout_hit;

    // The strobes carry no arbitration information; the terminals consume them directly.
    logic unused_strobes;
    assign unused_strobes = di_read_req ^ di_write;

    // Scanning from the top index down lets the lowest matching index win.
    always_comb begin
        term_sel = '0;
        for (int i = NUM_TERMS - 1; i >= 0; i--) begin
            if (di_term_addr == TERM_ADDRS[16*i +: 16]) begin
                term_sel    = '0;
                term_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_TERMS; i++) begin
            if (term_sel[i]) sel_data = sel_data | term_reg_datao[16*i +: 16];
        end
    end

    assign mapped   = |term_sel;
    assign sel_rrdy = |(term_read_rdy & term_sel);
    assign sel_wrdy = |(term_write_rdy & term_sel);
    assign any_mode = di_read_mode | di_write_mode;
    assign addr_chg = di_term_addr != addr_q;
    // An unmapped address always reads as ready, so it can never time out.
    assign rdy      = !mapped || (di_read_mode ? sel_rrdy : sel_wrdy);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = '0;
        timeout_hit  = 1'b0;
        unique case (state)
            IDLE:   if (any_mode) state_nxt = ACTIVE;
            ACTIVE: begin
                if (!any_mode) begin
                    state_nxt = IDLE;
                end else if (!rdy && !addr_chg) begin
                    if (wait_cnt == WAIT_LAST) begin
                        state_nxt   = FORCED;
                        timeout_hit = 1'b1;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 16'd1;
                    end
                end
            end
            FORCED: if (!any_mode) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        di_read_rdy  = 1'b0;
        di_write_rdy = 1'b0;
        if (resetb) begin
            if (state == FORCED || !mapped) begin
                di_read_rdy  = 1'b1;
                di_write_rdy = 1'b1;
            end else begin
                di_read_rdy  = sel_rrdy;
                di_write_rdy = sel_wrdy;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: there are no memories here, so every register is reset to a known value.
    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            addr_q       <= '0;
            di_reg_datao <= '0;
            timeout_err  <= 1'b0;
            err_count    <= '0;
        end else begin
            state        <= state_nxt;
            wait_cnt     <= wait_cnt_nxt;
            addr_q       <= di_term_addr;
            di_reg_datao <= (state_nxt == FORCED || !mapped) ? ERR_DATA : sel_data;
            if (timeout_hit) begin
                timeout_err <= 1'b1;
                err_count   <= err_clear ? 8'd1 : (err_count == 8'hFF ? 8'hFF : err_count + 8'd1);
            end else if (err_clear) begin
                timeout_err <= 1'b0;
                err_count   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_di_term_arbiter.sv
// Directed bench for di_term_arbiter with TIMEOUT = 8.
// The registered read data is checked through a queue of expected values.
module tb_di_term_arbiter;

    logic        ifclk = 1'b0;
    logic        resetb;
    logic [15:0] di_term_addr;
    logic        di_read_mode, di_write_mode, di_read_req, di_write;
    logic [63:0] term_reg_datao;
    logic [3:0]  term_read_rdy, term_write_rdy;
    logic        err_clear;
    logic [15:0] di_reg_datao;
    logic        di_read_rdy, di_write_rdy;
    logic [3:0]  term_sel;
    logic        timeout_err;
    logic [7:0]  err_count;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    int          err_model;

    always #5 ifclk = ~ifclk;

    di_term_arbiter #(.NUM_TERMS(4), .TIMEOUT(8)) dut (
        .ifclk          (ifclk),
        .resetb         (resetb),
        .di_term_addr   (di_term_addr),
        .di_read_mode   (di_read_mode),
        .di_write_mode  (di_write_mode),
        .di_read_req    (di_read_req),
        .di_write       (di_write),
        .term_reg_datao (term_reg_datao),
        .term_read_rdy  (term_read_rdy),
        .term_write_rdy (term_write_rdy),
        .err_clear      (err_clear),
        .di_reg_datao   (di_reg_datao),
        .di_read_rdy    (di_read_rdy),
        .di_write_rdy   (di_write_rdy),
        .term_sel       (term_sel),
        .timeout_err    (timeout_err),
        .err_count      (err_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Push the data expected after the coming edge, then compare it once the edge has passed.
    task automatic cyc(input logic [15:0] exp_d);
        exp_q.push_back(exp_d);
        @(posedge ifclk);
        #1;
        if (exp_q.size() != 0) check("di_reg_datao", 32'(di_reg_datao), 32'(exp_q.pop_front()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetb         = 1'b0;
        di_term_addr   = 16'd0;
        di_read_mode   = 1'b0;
        di_write_mode  = 1'b0;
        di_read_req    = 1'b0;
        di_write       = 1'b0;
        term_reg_datao = {16'h4444, 16'h3333, 16'h1234, 16'h1111};
        term_read_rdy  = 4'b1111;
        term_write_rdy = 4'b1111;
        err_clear      = 1'b0;
        #2;
        check("rst_read_rdy", 32'(di_read_rdy), 32'd0);
        check("rst_write_rdy", 32'(di_write_rdy), 32'd0);
        check("rst_data", 32'(di_reg_datao), 32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        @(negedge ifclk);
        @(negedge ifclk);
        resetb = 1'b1;
        @(posedge ifclk);
        #1;

        // Normal read from address 1.
        di_term_addr  = 16'd1;
        term_read_rdy = 4'b0010;
        term_write_rdy = 4'b0000;
        di_read_mode  = 1'b1;
        di_read_req   = 1'b1;
        #1;
        check("sel_addr1", 32'(term_sel), 32'h2);
        check("read_rdy_addr1", 32'(di_read_rdy), 32'd1);
        cyc(16'h1234);
        cyc(16'h1234);
        check("no_err_addr1", 32'(timeout_err), 32'd0);
        di_read_req  = 1'b0;
        di_read_mode = 1'b0;
        cyc(16'h1234);

        // Timeout on address 2: eight wait cycles, then forced completion.
        di_term_addr  = 16'd2;
        term_read_rdy = 4'b0000;
        di_read_mode  = 1'b1;
        for (int i = 0; i < 8; i++) cyc(16'h3333);
        check("pre_force_rdy", 32'(di_read_rdy), 32'd0);
        check("pre_force_err", 32'(timeout_err), 32'd0);
        cyc(16'hDEAD);
        check("force_err", 32'(timeout_err), 32'd1);
        check("force_cnt", 32'(err_count), 32'd1);
        check("force_read_rdy", 32'(di_read_rdy), 32'd1);
        check("force_write_rdy", 32'(di_write_rdy), 32'd1);
        cyc(16'hDEAD);
        di_read_mode = 1'b0;
        cyc(16'h3333);
        check("idle_read_rdy", 32'(di_read_rdy), 32'd0);

        // Unmapped address: always ready, error data, no timeout.
        di_term_addr = 16'h00FF;
        di_read_mode = 1'b1;
        #1;
        check("unmapped_sel", 32'(term_sel), 32'h0);
        for (int i = 0; i < 12; i++) cyc(16'hDEAD);
        check("unmapped_read_rdy", 32'(di_read_rdy), 32'd1);
        di_read_mode  = 1'b0;
        di_write_mode = 1'b1;
        di_write      = 1'b1;
        for (int i = 0; i < 12; i++) cyc(16'hDEAD);
        check("unmapped_write_rdy", 32'(di_write_rdy), 32'd1);
        check("unmapped_cnt", 32'(err_count), 32'd1);
        di_write      = 1'b0;
        di_write_mode = 1'b0;
        cyc(16'hDEAD);

        // Seven not-ready cycles then one ready cycle never reaches the timeout.
        di_term_addr = 16'd2;
        di_read_mode = 1'b1;
        cyc(16'h3333);
        for (int r = 0; r < 10; r++) begin
            term_read_rdy = 4'b0000;
            for (int i = 0; i < 7; i++) cyc(16'h3333);
            check("near_miss_rdy_low", 32'(di_read_rdy), 32'd0);
            term_read_rdy = 4'b0100;
            #1;
            check("near_miss_rdy_high", 32'(di_read_rdy), 32'd1);
            cyc(16'h3333);
        end
        check("near_miss_cnt", 32'(err_count), 32'd1);
        term_read_rdy = 4'b0000;
        di_read_mode  = 1'b0;
        cyc(16'h3333);

        // 300 more forced completions saturate the error counter.
        err_model = 1;
        for (int t = 0; t < 300; t++) begin
            di_read_mode = 1'b1;
            for (int i = 0; i < 8; i++) cyc(16'h3333);
            cyc(16'hDEAD);
            err_model = (err_model == 255) ? 255 : err_model + 1;
            check("sat_cnt", 32'(err_count), 32'(err_model));
            di_read_mode = 1'b0;
            cyc(16'h3333);
        end
        check("sat_final", 32'(err_count), 32'd255);

        // Clear coinciding with a new timeout leaves exactly one error.
        di_read_mode = 1'b1;
        for (int i = 0; i < 8; i++) cyc(16'h3333);
        err_clear = 1'b1;
        cyc(16'hDEAD);
        err_clear = 1'b0;
        check("clr_hit_err", 32'(timeout_err), 32'd1);
        check("clr_hit_cnt", 32'(err_count), 32'd1);
        di_read_mode = 1'b0;
        cyc(16'h3333);

        // Reset in the middle of an ACTIVE wait, released with the mode still high.
        term_write_rdy = 4'b0100;
        di_read_mode   = 1'b1;
        for (int i = 0; i < 5; i++) cyc(16'h3333);
        check("mid_write_rdy", 32'(di_write_rdy), 32'd1);
        #2;
        resetb = 1'b0;
        #1;
        check("mid_rst_write_rdy", 32'(di_write_rdy), 32'd0);
        check("mid_rst_read_rdy", 32'(di_read_rdy), 32'd0);
        check("mid_rst_data", 32'(di_reg_datao), 32'h0);
        check("mid_rst_err", 32'(timeout_err), 32'd0);
        check("mid_rst_cnt", 32'(err_count), 32'd0);
        #1;
        resetb = 1'b1;
        for (int i = 0; i < 8; i++) cyc(16'h3333);
        check("post_rst_active", 32'(timeout_err), 32'd0);
        cyc(16'hDEAD);
        check("post_rst_err", 32'(timeout_err), 32'd1);
        check("post_rst_cnt", 32'(err_count), 32'd1);
        check("post_rst_forced_wrdy", 32'(di_write_rdy), 32'd1);
        di_read_mode = 1'b0;
        cyc(16'h3333);

        // Plain clear.
        err_clear = 1'b1;
        cyc(16'h3333);
        err_clear = 1'b0;
        check("clr_err", 32'(timeout_err), 32'd0);
        check("clr_cnt", 32'(err_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
